// File: rtl/lcd_scanout.sv
// lcd_scanout: raster timing generator and framebuffer fetch stage for a
// raw parallel LCD. Walks h/v counters at one pixel per PIX_DIV clocks,
// drives the framebuffer read address and pipelines de/sync/data to the pins.
module lcd_scanout #(
  parameter int   H_ACTIVE = 480,
  parameter int   H_FP     = 8,
  parameter int   H_SYNC   = 4,
  parameter int   H_BP     = 43,
  parameter int   V_ACTIVE = 272,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 4,
  parameter int   V_BP     = 12,
  parameter int   PIX_DIV  = 4,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [31:0] rad,
  input  logic [7:0]  fb_dout,
  output logic        lcd_dclk,
  output logic        lcd_hsync,
  output logic        lcd_vsync,
  output logic        lcd_de,
  output logic [7:0]  lcd_data,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int PW = $clog2(PIX_DIV);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [PW-1:0] PH_LAST = PW'(PIX_DIV - 1);
  // dclk rises half a pixel period after the pin-update edge (which ends phase 1)
  localparam logic [PW-1:0] PH_RISE = PW'((1 + PIX_DIV / 2) % PIX_DIV);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_q, h_d;
  logic [VW-1:0]   v_q, v_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [31:0]     rad_q, rad_d;
  logic            ce_dly_q, ce_dly_d;   // stage1 was loaded on the previous edge
  logic            s1_de_q, s1_de_d;
  logic            s1_hs_q, s1_hs_d;
  logic            s1_vs_q, s1_vs_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic [7:0]      data_q, data_d;
  logic            dclk_q, dclk_d;
  logic            live_q, live_d;       // pins have carried at least one pixel
  logic            fs_q, fs_d;
  logic            pix_ce, h_act, v_act;

  // Next-state logic for counters, address, pixel pipeline and dclk
  always_comb begin
    state_d  = state_q;
    h_d      = h_q;
    v_d      = v_q;
    phase_d  = phase_q;
    rad_d    = rad_q;
    ce_dly_d = 1'b0;
    s1_de_d  = s1_de_q;
    s1_hs_d  = s1_hs_q;
    s1_vs_d  = s1_vs_q;
    de_d     = de_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    data_d   = data_q;
    dclk_d   = dclk_q;
    live_d   = live_q;
    pix_ce   = (state_q == RUN) && (phase_q == '0);
    h_act    = (h_q < H_ACT);
    v_act    = (v_q < V_ACT);

    unique case (state_q)
      IDLE: begin
        h_d     = '0;
        v_d     = '0;
        phase_d = '0;
        rad_d   = '0;
        s1_de_d = 1'b0;
        s1_hs_d = ~HS_POL;
        s1_vs_d = ~VS_POL;
        de_d    = 1'b0;
        hs_d    = ~HS_POL;
        vs_d    = ~VS_POL;
        data_d  = '0;
        dclk_d  = 1'b0;
        live_d  = 1'b0;
        if (en) state_d = RUN;
      end
      RUN, DRAIN: begin
        phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
        if (pix_ce) begin
          ce_dly_d = 1'b1;
          s1_de_d  = h_act && v_act;
          s1_hs_d  = (h_q >= H_SS && h_q < H_SE) ? HS_POL : ~HS_POL;
          s1_vs_d  = (v_q >= V_SS && v_q < V_SE) ? VS_POL : ~VS_POL;
          if (h_act && v_act) rad_d = rad_q + 32'd1;
          if (h_q == H_LAST) begin
            h_d = '0;
            if (v_q == V_LAST) begin
              v_d   = '0;
              rad_d = '0;
              // en only matters at the frame boundary
              if (!en) state_d = DRAIN;
            end else begin
              v_d = v_q + VW'(1);
            end
          end else begin
            h_d = h_q + HW'(1);
          end
        end
        if (ce_dly_q) begin
          de_d   = s1_de_q;
          hs_d   = s1_hs_q;
          vs_d   = s1_vs_q;
          data_d = s1_de_q ? fb_dout : 8'h00;
          dclk_d = 1'b0;
          live_d = 1'b1;
          if (state_q == DRAIN) state_d = IDLE;
        end else if (live_q && phase_q == PH_RISE) begin
          dclk_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered so the pulse coincides with the first pix_ce of the frame
    fs_d = (state_d == RUN) && (phase_d == '0) && (h_d == '0) && (v_d == '0);
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      h_q      <= '0;
      v_q      <= '0;
      phase_q  <= '0;
      rad_q    <= '0;
      ce_dly_q <= 1'b0;
      s1_de_q  <= 1'b0;
      s1_hs_q  <= ~HS_POL;
      s1_vs_q  <= ~VS_POL;
      de_q     <= 1'b0;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      data_q   <= '0;
      dclk_q   <= 1'b0;
      live_q   <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_q      <= h_d;
      v_q      <= v_d;
      phase_q  <= phase_d;
      rad_q    <= rad_d;
      ce_dly_q <= ce_dly_d;
      s1_de_q  <= s1_de_d;
      s1_hs_q  <= s1_hs_d;
      s1_vs_q  <= s1_vs_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      data_q   <= data_d;
      dclk_q   <= dclk_d;
      live_q   <= live_d;
      fs_q     <= fs_d;
    end
  end

  assign rad         = rad_q;
  assign lcd_dclk    = dclk_q;
  assign lcd_hsync   = hs_q;
  assign lcd_vsync   = vs_q;
  assign lcd_de      = de_q;
  assign lcd_data    = data_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_scanout.sv
// Bench for lcd_scanout: two instances (sync polarity 0 and 1) on a small
// geometry, checked every clock against a timeline model of the raster.
module tb_lcd_scanout;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT * PD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;

  logic [31:0] rad0, rad1;
  logic [7:0]  fb0, fb1, data0, data1;
  logic        dclk0, hs0, vs0, de0, fs0;
  logic        dclk1, hs1, vs1, de1, fs1;
  logic [7:0]  ram [0:HA*VA-1];

  int n_checks = 0;
  int n_fail = 0;

  // scan timeline model: m_tt counts clocks since the scan started
  bit m_run = 0;
  bit m_stop = 0;
  int m_tt = 0;

  always #5 clk = ~clk;

  lcd_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .PIX_DIV(PD), .HS_POL(1'b0), .VS_POL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .rad(rad0), .fb_dout(fb0),
    .lcd_dclk(dclk0), .lcd_hsync(hs0), .lcd_vsync(vs0), .lcd_de(de0),
    .lcd_data(data0), .frame_start(fs0));

  lcd_scanout #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
                .PIX_DIV(PD), .HS_POL(1'b1), .VS_POL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .rad(rad1), .fb_dout(fb1),
    .lcd_dclk(dclk1), .lcd_hsync(hs1), .lcd_vsync(vs1), .lcd_de(de1),
    .lcd_data(data1), .frame_start(fs1));

  // framebuffer models, one clock read latency
  always @(posedge clk) begin
    fb0 <= (int'(rad0) < HA*VA) ? ram[rad0[3:0]] : 8'h00;
    fb1 <= (int'(rad1) < HA*VA) ? ram[rad1[3:0]] : 8'h00;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t tt=%0d)", tag, got, exp, $time, m_tt);
    end
  endtask

  task automatic check_outputs();
    int p, q, h, v;
    bit rad_known;
    logic [31:0] e_rad;
    logic e_fs, e_de, e_hs, e_vs, e_dclk;
    logic [7:0] e_data;
    rad_known = 1; e_rad = 0; e_fs = 0;
    e_de = 0; e_hs = 0; e_vs = 0; e_dclk = 0; e_data = 8'h00;
    if (m_run) begin
      e_fs = (m_tt % FRAME == 0);
      rad_known = 0;
      if (m_tt % PD == 0) begin
        p = (m_tt / PD) % (HT * VT);
        h = p % HT; v = p / HT;
        if (h < HA && v < VA) begin
          rad_known = 1;
          e_rad = 32'(v * HA + h);
        end
      end
      // pins show the pixel whose counter state was two clocks earlier
      if (m_tt >= 2) begin
        q = ((m_tt - 2) / PD) % (HT * VT);
        h = q % HT; v = q / HT;
        e_de = (h < HA && v < VA);
        e_hs = (h >= HA + HF && h < HA + HF + HS);
        e_vs = (v >= VA + VF && v < VA + VF + VS);
        e_data = e_de ? 8'(16 + v * HA + h) : 8'h00;
        e_dclk = ((m_tt - 2) % PD) >= PD / 2;
      end
    end
    if (rad_known) begin
      check_val("rad0", rad0, e_rad);
      check_val("rad1", rad1, e_rad);
    end
    check_val("frame_start0", {31'b0, fs0}, {31'b0, e_fs});
    check_val("frame_start1", {31'b0, fs1}, {31'b0, e_fs});
    check_val("de0", {31'b0, de0}, {31'b0, e_de});
    check_val("de1", {31'b0, de1}, {31'b0, e_de});
    check_val("data0", {24'b0, data0}, {24'b0, e_data});
    check_val("data1", {24'b0, data1}, {24'b0, e_data});
    check_val("dclk0", {31'b0, dclk0}, {31'b0, e_dclk});
    check_val("dclk1", {31'b0, dclk1}, {31'b0, e_dclk});
    check_val("hsync_pol0", {31'b0, hs0}, {31'b0, ~e_hs});
    check_val("vsync_pol0", {31'b0, vs0}, {31'b0, ~e_vs});
    check_val("hsync_pol1", {31'b0, hs1}, {31'b0, e_hs});
    check_val("vsync_pol1", {31'b0, vs1}, {31'b0, e_vs});
  endtask

  // one clock: advance the model with the inputs seen at this edge, then check
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_run = 0; m_tt = 0; m_stop = 0;
    end else if (!m_run) begin
      if (en) begin
        m_run = 1; m_tt = 0; m_stop = 0;
      end
    end else begin
      if (m_tt % FRAME == FRAME - PD && !en) m_stop = 1;
      if (m_stop && m_tt % FRAME == FRAME - 1) m_run = 0;
      else m_tt++;
    end
    #1;
    check_outputs();
  endtask

  // advance until the model sits at the given clock offset within a frame
  task automatic wait_frame_pos(input string tag, input int pos);
    int i;
    i = 0;
    while (!(m_run && (m_tt % FRAME) == pos) && i < 3 * FRAME) begin
      tick();
      i++;
    end
    if (i >= 3 * FRAME) check_val(tag, 32'(i), 32'(3 * FRAME - 1));
  endtask

  initial begin
    int off, i;
    for (int k = 0; k < HA*VA; k++) ram[k] = 8'(16 + k);

    // start-up from reset with en held high
    rst_n = 1'b0; en = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2 * FRAME + $urandom_range(0, 20)) tick();

    // drop en somewhere in line 1; frame must complete, then idle
    off = $urandom_range(0, HT * PD - 1);
    wait_frame_pos("wait_line1", HT * PD + off);
    en = 1'b0;
    i = 0;
    while (m_run && i < 2 * FRAME) begin tick(); i++; end
    if (i >= 2 * FRAME) check_val("wait_idle", 32'(i), 32'(2 * FRAME - 1));
    repeat ($urandom_range(5, 30)) tick();
    en = 1'b1;
    repeat (FRAME + $urandom_range(0, 30)) tick();

    // one-clock reset in the middle of line 2
    off = $urandom_range(0, HT * PD - 1);
    wait_frame_pos("wait_line2", 2 * HT * PD + off);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (FRAME + 10) tick();

    // random en toggles and occasional resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 149) == 0) en = ~en;
      rst_n = ($urandom_range(0, 399) != 0);
      tick();
    end
    rst_n = 1'b1; en = 1'b0;
    repeat (2 * FRAME) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
